lsu: RTL

Load/store unit sitting directly downstream of the ALU: it takes the effective address the ALU computes (rs1 + imm), performs one RV32I load or store over a single-outstanding request/acknowledge memory bus, and returns sign- or zero-extended load data for writeback. It checks alignment and width encoding before issuing, stalls the core via `busy`, and aborts on a bus timeout.

---
 rtl/lsu.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// RV32I load/store unit: validates width/alignment, drives one request on a
// single-outstanding req/ack bus, and returns extended load data.
module lsu #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            start_i,
   input  logic            we_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] addr_i,
   input  logic [XLEN-1:0] wdata_i,
   output logic            busy_o,
   output logic            done_o,
   output logic            err_o,
   output logic [XLEN-1:0] rdata_o,
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [XLEN-1:0] mem_addr_o,
   output logic [XLEN-1:0] mem_wdata_o,
   output logic [3:0]      mem_be_o,
   input  logic [XLEN-1:0] mem_rdata_i,
   input  logic            mem_ack_i
);

   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        f3_q, f3_d;
   logic [1:0]        lane_q, lane_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [XLEN-1:0]   rdata_q, rdata_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
   logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
   logic [3:0]        mem_be_q, mem_be_d;

   logic              legal_c;
   logic              aligned_c;
   logic [3:0]        be_c;
   logic [XLEN-1:0]   wdata_enc_c;
   logic [XLEN-1:0]   shifted_c;
   logic [XLEN-1:0]   load_ext_c;
   logic              timeout_hit_c;

   // Width legality and alignment of the incoming request
   always_comb begin
      legal_c   = 1'b0;
      aligned_c = 1'b0;
      case (funct3_i)
         3'b000:  begin legal_c = 1'b1;   aligned_c = 1'b1; end
         3'b001:  begin legal_c = 1'b1;   aligned_c = ~addr_i[0]; end
         3'b010:  begin legal_c = 1'b1;   aligned_c = (addr_i[1:0] == 2'b00); end
         3'b100:  begin legal_c = ~we_i;  aligned_c = 1'b1; end
         3'b101:  begin legal_c = ~we_i;  aligned_c = ~addr_i[0]; end
         default: begin legal_c = 1'b0;   aligned_c = 1'b0; end
      endcase
   end

   // Byte enables and lane-replicated store data; loads reuse the same enables
   always_comb begin
      case (funct3_i[1:0])
         2'b00: begin
            be_c        = 4'b0001 << addr_i[1:0];
            wdata_enc_c = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            be_c        = 4'b0011 << addr_i[1:0];
            wdata_enc_c = {2{wdata_i[15:0]}};
         end
         default: begin
            be_c        = 4'b1111;
            wdata_enc_c = wdata_i;
         end
      endcase
   end

   // Load extraction from the captured lane
   always_comb begin
      shifted_c = mem_rdata_i >> {lane_q, 3'b000};
      case (f3_q)
         3'b000:  load_ext_c = {{(XLEN-8){shifted_c[7]}}, shifted_c[7:0]};
         3'b001:  load_ext_c = {{(XLEN-16){shifted_c[15]}}, shifted_c[15:0]};
         3'b100:  load_ext_c = {{(XLEN-8){1'b0}}, shifted_c[7:0]};
         3'b101:  load_ext_c = {{(XLEN-16){1'b0}}, shifted_c[15:0]};
         default: load_ext_c = mem_rdata_i;
      endcase
   end

   assign timeout_hit_c = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      f3_d        = f3_q;
      lane_d      = lane_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      rdata_d     = rdata_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               f3_d   = funct3_i;
               lane_d = addr_i[1:0];
               cnt_d  = '0;
               if (legal_c && aligned_c) begin
                  state_d     = REQ;
                  mem_req_d   = 1'b1;
                  mem_we_d    = we_i;
                  mem_addr_d  = {addr_i[XLEN-1:2], 2'b00};
                  mem_wdata_d = wdata_enc_c;
                  mem_be_d    = be_c;
               end else begin
                  state_d = RESP;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end
            end
         end
         REQ: begin
            // An ack arriving on the limit cycle still counts as success
            if (mem_ack_i) begin
               state_d   = RESP;
               done_d    = 1'b1;
               mem_req_d = 1'b0;
               if (!mem_we_q) rdata_d = load_ext_c;
            end else if (timeout_hit_c) begin
               state_d   = RESP;
               done_d    = 1'b1;
               err_d     = 1'b1;
               mem_req_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP: state_d = IDLE;
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         f3_q        <= '0;
         lane_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         f3_q        <= f3_d;
         lane_q      <= lane_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign rdata_o     = rdata_q;
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign mem_be_o    = mem_be_q;

endmodule
